muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width and iteration count.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request a new M-extension operation; sampled only in IDLE.
REQ-005 SHALL have port: funct3  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port: op_a  input  XLEN  rs1 value; captured with start.
REQ-007 SHALL have port: op_b  input  XLEN  rs2 value; captured with start.
REQ-008 SHALL have port: flush  input  1  abort any in-flight operation.
REQ-009 SHALL have port: busy  output  1  high while state is not IDLE.
REQ-010 SHALL have port: stall  output  1  combinational pipeline hold: (start & IDLE & ~flush) | CALC.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; result valid this cycle.
REQ-012 SHALL have port: result  output  XLEN  registered result; holds last value until next done.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL move IDLE->CALC on start & ~flush, latching funct3, op_a, op_b, operand signs and absolute values; iteration counter cleared to 0.
REQ-015 SHALL move IDLE->DONE directly (latency 1) for special cases: divide-by-zero and signed overflow (0x80000000 / -1 on DIV/REM).
REQ-016 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per CALC cycle on unsigned magnitudes; counter increments each step.
REQ-017 SHALL move CALC->DONE on the edge completing step XLEN-1 (XLEN CALC cycles); done is high in the first cycle after that edge (cycle XLEN+1 after the start cycle).
REQ-018 SHALL move DONE->IDLE unconditionally on the next edge; start during DONE is ignored.
REQ-019 SHALL ignore start whenever state is not IDLE.
REQ-020 SHALL sign-treat operands: MUL/MULH/DIV/REM both signed; MULHSU op_a signed, op_b unsigned; MULHU/DIVU/REMU unsigned.
REQ-021 SHALL form a 2*XLEN-bit product, negated when effective signs differ; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits.
REQ-022 SHALL negate quotient when operand signs differ and negate remainder when dividend negative (remainder takes dividend sign).
REQ-023 SHALL return for divide-by-zero: quotient all-ones (DIV, DIVU), remainder = op_a (REM, REMU).
REQ-024 SHALL return for signed overflow: DIV = 0x80000000, REM = 0.
REQ-025 SHALL, on flush in any state, go to IDLE on the next edge with no done pulse and result unchanged; flush has priority over start and over CALC->DONE.
REQ-026 SHALL load result register only on the edge entering DONE.

Reset
REQ-027 SHALL on rst force state IDLE, counter 0, busy 0, done 0, result 0, internal operand registers 0, on the next edge, including mid-CALC.
REQ-028 SHALL give rst priority over flush and start.

Structure
REQ-029 SHALL place M-extension funct3 encodings, the M opcode/funct7 constants and FSM state encodings in the shared Defines.vh header.
REQ-030 SHALL split into controller FSM (muldiv_ctrl) and one sub-module muldiv_datapath holding accumulator/shift registers, step adder/subtractor and sign fix-up.
REQ-031 SHALL contain no multiplier or divider operator; one XLEN+1-bit adder shared by both iteration kinds.

Verification
REQ-032 SHALL cover MUL 7 x 0xFFFFFFFD -> done in cycle 33 after start, result 0xFFFFFFEB; stall high cycles 0-32.
REQ-033 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-034 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-035 SHALL cover DIVU 5 / 0 -> 0xFFFFFFFF, REM 5 / 0 -> 5, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; each done in cycle 1 after start.
REQ-036 SHALL cover flush at CALC step 10 -> no done, busy low next cycle, result unchanged; start during CALC ignored; fresh start in IDLE accepted.
REQ-037 SHALL cover rst asserted at CALC step 20 -> all outputs at reset values after the edge; subsequent MUL 3 x 4 -> 12.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants for the RV32M multiply/divide unit: FSM states,
// M-extension encodings and operand sign-treatment helpers.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV, REM
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide datapath: works on unsigned magnitudes with a
// single XLEN+1-bit adder, then restores signs on the final result.
module muldiv_datapath
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            special,
  output logic [XLEN-1:0] special_res,
  output logic [XLEN-1:0] calc_res
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // hi: product high half / partial remainder; lo: multiplier / quotient
  logic [XLEN-1:0]   hi, lo, opd;
  logic [2:0]        f3_q;
  logic              a_neg, b_neg;

  logic              in_a_neg, in_b_neg, div_zero, ovf;
  logic [XLEN-1:0]   in_a_abs, in_b_abs;
  logic [XLEN:0]     add_a, add_b, sum;
  logic              add_cin;
  logic [XLEN-1:0]   hi_next, lo_next;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign in_a_neg = a_is_signed(funct3) & op_a[XLEN-1];
  assign in_b_neg = b_is_signed(funct3) & op_b[XLEN-1];
  assign in_a_abs = in_a_neg ? (~op_a + XLEN'(1)) : op_a;
  assign in_b_abs = in_b_neg ? (~op_b + XLEN'(1)) : op_b;

  assign div_zero = funct3[2] & (op_b == '0);
  assign ovf      = funct3[2] & ~funct3[0] & (op_a == INT_MIN) & (op_b == '1);
  assign special  = div_zero | ovf;

  // Results that skip iteration entirely: divide-by-zero and signed overflow
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? op_a : '1;
    else if (ovf)
      special_res = funct3[1] ? '0 : INT_MIN;
  end

  // Shared adder operands: add-or-skip for multiply, trial subtract for divide
  always_comb begin
    add_a   = {1'b0, hi};
    add_b   = lo[0] ? {1'b0, opd} : '0;
    add_cin = 1'b0;
    if (f3_q[2]) begin
      add_a   = {hi, lo[XLEN-1]};
      add_b   = ~{1'b0, opd};
      add_cin = 1'b1;
    end
  end

  assign sum = add_a + add_b + {{XLEN{1'b0}}, add_cin};

  // Next accumulator state; sum[XLEN] set means the trial subtract borrowed
  always_comb begin
    hi_next = sum[XLEN:1];
    lo_next = {sum[0], lo[XLEN-1:1]};
    if (f3_q[2]) begin
      hi_next = sum[XLEN] ? add_a[XLEN-1:0] : sum[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], ~sum[XLEN]};
    end
  end

  // Sign fix-up taken from the next-state values so the final step's
  // outcome can be registered on the same edge that completes it
  assign prod     = {hi_next, lo_next};
  assign prod_fix = (a_neg ^ b_neg) ? (~prod + (2*XLEN)'(1)) : prod;
  assign quo_fix  = (a_neg ^ b_neg) ? (~lo_next + XLEN'(1)) : lo_next;
  assign rem_fix  = a_neg ? (~hi_next + XLEN'(1)) : hi_next;

  // Select the architectural result for the latched operation
  always_comb begin
    calc_res = prod_fix[2*XLEN-1:XLEN];
    if (f3_q == F3_MUL)
      calc_res = prod_fix[XLEN-1:0];
    else if (f3_q[2])
      calc_res = f3_q[1] ? rem_fix : quo_fix;
  end

  // Operand capture on accept, one iteration per step
  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      opd   <= '0;
      f3_q  <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
    end else if (load) begin
      hi    <= '0;
      lo    <= in_a_abs;
      opd   <= in_b_abs;
      f3_q  <= funct3;
      a_neg <= in_a_neg;
      b_neg <= in_b_neg;
    end else if (step) begin
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide controller: IDLE/CALC/DONE sequencing, iteration
// count, pipeline stall and the result register.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);

  state_e            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              load, step_en, last_step, special;
  logic [XLEN-1:0]   special_res, calc_res, result_q;

  assign load      = (state == ST_IDLE) & bus.start & ~bus.flush;
  assign step_en   = (state == ST_CALC) & ~bus.flush;
  assign last_step = (cnt == CNT_W'(XLEN-1));

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step_en),
    .funct3      (bus.funct3),
    .op_a        (bus.op_a),
    .op_b        (bus.op_b),
    .special     (special),
    .special_res (special_res),
    .calc_res    (calc_res)
  );

  // Next-state logic; flush wins over start and over finishing a calculation
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (load) state_next = special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (bus.flush)     state_next = ST_IDLE;
        else if (last_step) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Iteration counter: cleared on accept, advanced once per CALC step
  always_ff @(posedge clk) begin
    if (rst)          cnt <= '0;
    else if (load)    cnt <= '0;
    else if (step_en) cnt <= cnt + CNT_W'(1);
  end

  // Result register loads only on the edge entering DONE
  always_ff @(posedge clk) begin
    if (rst)
      result_q <= '0;
    else if (state_next == ST_DONE)
      result_q <= (state == ST_IDLE) ? special_res : calc_res;
  end

  assign bus.busy   = (state != ST_IDLE);
  assign bus.stall  = load | (state == ST_CALC);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed and randomized bench for muldiv_ctrl with an arithmetic reference model.
module tb_muldiv_ctrl;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  muldiv_ctrl_if #(.XLEN(XLEN)) bus ();

  muldiv_ctrl #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics expressed with native arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic signed [31:0] a32, b32;
    sa = $signed(a); sb = $signed(b);
    ua = {32'd0, a}; ub = {32'd0, b};
    a32 = $signed(a); b32 = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return a32 / b32;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return a32 % b32;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One operation: checks stall every cycle, done latency, result, return to IDLE.
  // poke drives start mid-CALC and during DONE, both of which must be ignored.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit poke);
    logic [31:0] exp;
    int lat;
    int cyc;
    bit seen;
    exp  = model(f3, a, b);
    lat  = latency(f3, a, b);
    seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
    #1 chk({tag, "_stall_c0"}, 32'(bus.stall), 32'd1);
    for (cyc = 1; cyc <= XLEN + 8; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom;
      if (poke && (cyc == 5 || cyc == lat)) begin
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_b = 32'd0;
      end
      #1;
      if (bus.done) begin seen = 1; break; end
      chk({tag, "_stall"}, 32'(bus.stall), 32'(cyc < lat));
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_result"}, bus.result, exp);
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done_after"}, 32'(bus.done), 32'd0);
    chk({tag, "_result_hold"}, bus.result, exp);
    last_res = exp;
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.flush = 1'b0;
    bus.funct3 = 3'd0; bus.op_a = '0; bus.op_b = '0; last_res = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("reset_busy",   32'(bus.busy),  32'd0);
    chk("reset_done",   32'(bus.done),  32'd0);
    chk("reset_stall",  32'(bus.stall), 32'd0);
    chk("reset_result", bus.result,     32'd0);

    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, "mul_7",      0);
    chk("mul_7_value", last_res, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu",      0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh",       0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         "mulhsu",     0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         "div",        0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         "rem",        0);
    run_op(3'd5, 32'd100,       32'd7,         "divu",       0);
    run_op(3'd7, 32'd100,       32'd7,         "remu",       0);
    run_op(3'd5, 32'd5,         32'd0,         "divu_zero",  0);
    run_op(3'd6, 32'd5,         32'd0,         "rem_zero",   0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",    0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf",    0);
    run_op(3'd0, 32'd9,         32'd11,        "mul_poke",   1);

    // Flush while CALC is at step 10
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 11) bus.flush = 1'b1;
      #1 chk("flush_no_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("flush_busy",   32'(bus.busy), 32'd0);
    chk("flush_done",   32'(bus.done), 32'd0);
    chk("flush_result", bus.result,    last_res);
    run_op(3'd5, 32'd100, 32'd7, "divu_after_flush", 0);

    // Reset while CALC is at step 20
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = $urandom; bus.op_b = $urandom;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 21) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy",   32'(bus.busy),  32'd0);
    chk("rst_mid_done",   32'(bus.done),  32'd0);
    chk("rst_mid_stall",  32'(bus.stall), 32'd0);
    chk("rst_mid_result", bus.result,     32'd0);
    run_op(3'd0, 32'd3, 32'd4, "mul_3x4", 0);
    chk("mul_3x4_value", last_res, 32'd12);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run_op(f3, a, b, "random", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
